// File: rtl/block_copy_engine.sv
// Word-granular block copy / fill engine driving a single-port data memory.
// Copy moves one word per READ+WRITE pair; fill writes one word per cycle.
module block_copy_engine #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic [DATA_WIDTH-1:0] fill_value,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_write,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_data_read,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] words_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(0);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = DATA_WIDTH'(0);

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   src_r, src_s;
  logic [ADDR_WIDTH-1:0]   dst_r, dst_s;
  logic [ADDR_WIDTH-1:0]   len_r, len_s;
  logic [ADDR_WIDTH-1:0]   cnt_r, cnt_s, cnt_inc_s;
  logic                    mode_r, mode_s;
  logic [DATA_WIDTH-1:0]   fill_r, fill_s;
  logic [DATA_WIDTH-1:0]   hold_r, hold_s;

  logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
  logic [DATA_WIDTH-1:0]   wdata_r, wdata_s;
  logic                    rd_r, rd_s;
  logic                    wr_r, wr_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;

  assign cnt_inc_s = cnt_r + ADDR_ONE;

  // Next-state and next-register computation for the transfer sequencer.
  always_comb begin
    state_s = state_r;
    src_s   = src_r;
    dst_s   = dst_r;
    len_s   = len_r;
    cnt_s   = cnt_r;
    mode_s  = mode_r;
    fill_s  = fill_r;
    hold_s  = hold_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          src_s  = src_addr;
          dst_s  = dst_addr;
          len_s  = length;
          mode_s = mode;
          fill_s = fill_value;
          cnt_s  = ADDR_ZERO;
          if (length == ADDR_ZERO) begin
            state_s = DONE;
          end else if (mode) begin
            state_s = WRITE;
          end else begin
            state_s = READ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        // An aborted read is dropped: the holding register keeps its old word.
        if (abort) begin
          state_s = DONE;
        end else begin
          hold_s  = mem_data_read;
          state_s = WRITE;
        end
      end
      WRITE: begin
        cnt_s = cnt_inc_s;
        if (abort || (cnt_inc_s == len_r)) begin
          state_s = DONE;
        end else if (mode_r) begin
          state_s = WRITE;
        end else begin
          state_s = READ;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output decode for the upcoming state, so the registered outputs are a pure function of state_r.
  always_comb begin
    addr_s  = ADDR_ZERO;
    wdata_s = DATA_ZERO;
    rd_s    = 1'b0;
    wr_s    = 1'b0;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    case (state_s)
      READ: begin
        addr_s = src_s + cnt_s;
        rd_s   = 1'b1;
        busy_s = 1'b1;
      end
      WRITE: begin
        addr_s  = dst_s + cnt_s;
        wdata_s = mode_s ? fill_s : hold_s;
        wr_s    = 1'b1;
        busy_s  = 1'b1;
      end
      DONE: begin
        done_s = 1'b1;
      end
      IDLE: begin
        done_s = 1'b0;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  // State, transfer context and registered memory-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      src_r   <= ADDR_ZERO;
      dst_r   <= ADDR_ZERO;
      len_r   <= ADDR_ZERO;
      cnt_r   <= ADDR_ZERO;
      mode_r  <= 1'b0;
      fill_r  <= DATA_ZERO;
      hold_r  <= DATA_ZERO;
      addr_r  <= ADDR_ZERO;
      wdata_r <= DATA_ZERO;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      src_r   <= src_s;
      dst_r   <= dst_s;
      len_r   <= len_s;
      cnt_r   <= cnt_s;
      mode_r  <= mode_s;
      fill_r  <= fill_s;
      hold_r  <= hold_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
      rd_r    <= rd_s;
      wr_r    <= wr_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign mem_address    = addr_r;
  assign mem_data_write = wdata_r;
  assign mem_read       = rd_r;
  assign mem_write      = wr_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign words_done     = cnt_r;

endmodule

// File: tb/tb_block_copy_engine.sv
// Randomized self-checking bench for block_copy_engine with a word-level
// reference model (golden memory plus expected access trace).
module tb_block_copy_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, mode, abort;
  logic [15:0] src_addr, dst_addr, length, fill_value;
  logic [15:0] mem_address, mem_data_write, mem_data_read, words_done;
  logic        mem_read, mem_write, busy, done;

  logic [15:0] mem  [0:65535];
  logic [15:0] gmem [0:65535];

  int errors = 0;
  int checks = 0;

  block_copy_engine #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_value(fill_value), .abort(abort),
    .mem_address(mem_address), .mem_data_write(mem_data_write),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_data_read(mem_data_read), .busy(busy), .done(done),
    .words_done(words_done)
  );

  always #5 clk = ~clk;

  assign mem_data_read = mem_read ? mem[mem_address] : 16'h0000;

  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_data_write;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic scramble_inputs();
    mode       = 1'($urandom);
    src_addr   = 16'($urandom);
    dst_addr   = 16'($urandom);
    length     = 16'($urandom);
    fill_value = 16'($urandom);
  endtask

  // One transfer: model -> drive -> compare. ab_word < 0 means no abort.
  task automatic run_xfer(input bit m, input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] l, input logic [15:0] f,
                          input int ab_word, input bit ab_read);
    logic [33:0] exp_q[$];
    logic [33:0] act_q[$];
    logic [15:0] sa, da, v;
    int nw, busy_exp, ab_cycle, cycle, done_at, busy_cnt, n;
    bit rd_hit;
    nw = 0;
    rd_hit = 1'b0;
    for (int i = 0; i < int'(l); i++) begin
      sa = s + 16'(i);
      da = d + 16'(i);
      if (!m) begin
        exp_q.push_back({2'b01, sa, gmem[sa]});
        if (ab_word == i && ab_read) begin
          rd_hit = 1'b1;
          break;
        end
        v = gmem[sa];
      end else begin
        v = f;
      end
      exp_q.push_back({2'b10, da, v});
      gmem[da] = v;
      nw++;
      if (ab_word == i) break;
    end
    busy_exp = m ? nw : (2 * nw + (rd_hit ? 1 : 0));
    if (ab_word < 0) ab_cycle = -1;
    else if (m) ab_cycle = ab_word + 1;
    else ab_cycle = ab_read ? (2 * ab_word + 1) : (2 * ab_word + 2);

    @(negedge clk);
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; length = l; fill_value = f;
    abort = 1'($urandom);
    @(posedge clk);
    #1;
    scramble_inputs();
    abort = 1'b0;
    cycle = 0; done_at = 0; busy_cnt = 0;
    while (cycle < 64 && done_at == 0) begin
      @(negedge clk);
      cycle++;
      if (busy) busy_cnt++;
      check("rd_wr_exclusive", {63'd0, mem_read & mem_write}, 64'd0);
      if (mem_read) act_q.push_back({2'b01, mem_address, mem_data_read});
      if (mem_write) act_q.push_back({2'b10, mem_address, mem_data_write});
      scramble_inputs();
      abort = (cycle == ab_cycle);
      if (done) begin
        done_at = cycle;
        check("busy_in_done", {63'd0, busy}, 64'd0);
        start = 1'b0;
        abort = 1'($urandom);
      end else begin
        start = 1'($urandom);
      end
    end
    start = 1'b0;
    check("done_cycle", done_at, busy_exp + 1);
    check("busy_cycles", busy_cnt, busy_exp);
    check("words_done", words_done, nw);
    check("access_count", act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("access", act_q[i], exp_q[i]);
    for (int i = 0; i < int'(l); i++) begin
      da = d + 16'(i);
      check("mem_dst", mem[da], gmem[da]);
    end
    abort = 1'b0;
    @(negedge clk);
    check("idle_outputs", {done, busy, mem_read, mem_write, mem_address, mem_data_write},
          64'd0);
    check("words_done_hold", words_done, nw);
  endtask

  task automatic reset_mid_transfer(input logic [15:0] s, input logic [15:0] d);
    @(negedge clk);
    start = 1'b1; mode = 1'b0; src_addr = s; dst_addr = d; length = 16'd10;
    fill_value = 16'h0000; abort = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rst_read_addr", {mem_read, mem_address}, {1'b1, s + 16'd1});
    gmem[d] = gmem[s];
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    check("rst_outputs", {done, busy, mem_read, mem_write, mem_address, mem_data_write,
          words_done}, 64'd0);
    @(negedge clk);
    check("rst_hold", {done, busy, mem_read, mem_write, words_done}, 64'd0);
    start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) check("rst_mem", mem[d + 16'(i)], gmem[d + 16'(i)]);
  endtask

  initial begin
    logic [15:0] s, d, l;
    bit m;
    int aw;
    for (int i = 0; i < 65536; i++) begin
      mem[i]  = 16'($urandom);
      gmem[i] = mem[i];
    end
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    scramble_inputs();
    #1;
    check("reset_outputs", {done, busy, mem_read, mem_write, mem_address, mem_data_write,
          words_done}, 64'd0);
    #12 rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      mem[16'h0010 + 16'(i)]  = 16'h00A1 + 16'(i);
      gmem[16'h0010 + 16'(i)] = 16'h00A1 + 16'(i);
    end
    run_xfer(1'b0, 16'h0010, 16'h0100, 16'd4, 16'h0000, -1, 1'b0);
    check("a1_copied", mem[16'h0103], 16'h00A4);
    run_xfer(1'b1, 16'h0000, 16'h0020, 16'd3, 16'hBEEF, -1, 1'b0);
    run_xfer(1'b0, 16'h1234, 16'h4321, 16'd0, 16'h0000, -1, 1'b0);
    run_xfer(1'b0, 16'hFFFE, 16'h7FFF, 16'd3, 16'h0000, -1, 1'b0);
    run_xfer(1'b0, 16'h0200, 16'h0300, 16'd10, 16'h0000, 2, 1'b0);
    run_xfer(1'b0, 16'h0400, 16'h0500, 16'd6, 16'h0000, 1, 1'b1);
    run_xfer(1'b1, 16'h0000, 16'hFFFD, 16'd5, 16'h5A5A, 3, 1'b0);
    run_xfer(1'b0, 16'h0600, 16'h0602, 16'd6, 16'h0000, -1, 1'b0);
    reset_mid_transfer(16'h0700, 16'h0800);
    run_xfer(1'b1, 16'h0000, 16'h0900, 16'd2, 16'hC0DE, -1, 1'b0);

    for (int t = 0; t < 24; t++) begin
      m = 1'($urandom);
      l = 16'($urandom_range(0, 12));
      case ($urandom_range(0, 2))
        0: s = 16'($urandom);
        1: s = 16'hFFF8 + 16'($urandom_range(0, 7));
        default: s = 16'($urandom_range(0, 31));
      endcase
      d = ($urandom_range(0, 1) == 0) ? 16'($urandom) : s + 16'($urandom_range(0, 4));
      aw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
      run_xfer(m, s, d, l, 16'($urandom), aw, ((!m) && ($urandom_range(0, 1) == 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/block_copy_engine.md
BLOCK_COPY_ENGINE -- requirements
Module: block_copy_engine

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: width of the memory address and of the length/count fields.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: width of a memory word.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request a transfer; sampled only in IDLE.
REQ-006 SHALL have port mode, input, 1 bit: 0 = copy, 1 = fill.
REQ-007 SHALL have port src_addr, input, ADDR_WIDTH: first source word address (copy mode only).
REQ-008 SHALL have port dst_addr, input, ADDR_WIDTH: first destination word address.
REQ-009 SHALL have port length, input, ADDR_WIDTH: number of words to transfer; 0 is legal.
REQ-010 SHALL have port fill_value, input, DATA_WIDTH: word written in fill mode.
REQ-011 SHALL have port abort, input, 1 bit: terminate the active transfer.
REQ-012 SHALL have port mem_address, output, ADDR_WIDTH: word address to the data memory.
REQ-013 SHALL have port mem_data_write, output, DATA_WIDTH: write data to the data memory.
REQ-014 SHALL have port mem_read, output, 1 bit: read enable; read data is combinational, valid in the same cycle.
REQ-015 SHALL have port mem_write, output, 1 bit: write enable; the memory commits on the rising clk edge.
REQ-016 SHALL have port mem_data_read, input, DATA_WIDTH: read data returned by the data memory.
REQ-017 SHALL have port busy, output, 1 bit: high in READ and WRITE.
REQ-018 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-019 SHALL have port words_done, output, ADDR_WIDTH: count of words written in the current or last transfer.

Function
REQ-020 SHALL implement the states IDLE, READ, WRITE and DONE.
REQ-021 SHALL latch src_addr, dst_addr, length, mode and fill_value on the edge where start is high in IDLE, clear words_done, and hold the latched values for the whole transfer.
REQ-022 SHALL leave IDLE on a start edge as follows: length = 0 -> DONE; copy -> READ; fill -> WRITE.
REQ-023 SHALL, in READ, drive mem_address = src + words_done, mem_read = 1 and mem_write = 0, capture mem_data_read into a holding register at the edge, and go to WRITE.
REQ-024 SHALL, in WRITE, drive mem_address = dst + words_done and mem_write = 1, with mem_data_write = the holding register (copy) or fill_value (fill), then increment words_done at the edge.
REQ-025 SHALL leave WRITE to DONE when the incremented words_done equals length; otherwise copy -> READ and fill -> stay in WRITE.
REQ-026 SHALL therefore take 2 cycles per word in copy mode and 1 cycle per word in fill mode, excluding the single DONE cycle.
REQ-027 SHALL hold done = 1 and busy = 0 for exactly one cycle in DONE, then return to IDLE.
REQ-028 SHALL compute all address arithmetic modulo 2^ADDR_WIDTH, so 16'hFFFF + 1 wraps to 16'h0000.
REQ-029 SHALL copy in ascending address order, one full read-then-write per word; an overlap with dst > src propagates already-written words, and that behaviour is defined.
REQ-030 SHALL never assert mem_read and mem_write in the same cycle.
REQ-031 SHALL drive mem_read, mem_write, mem_address and mem_data_write to 0 in IDLE and DONE.
REQ-032 SHALL decode mem_* outputs from the current state and registers only (Moore).
REQ-033 SHALL let a write driven in the cycle abort is sampled complete, and count it; the next state is then DONE.
REQ-034 SHALL, when abort is sampled in READ, discard the read, leave words_done unchanged and go to DONE.
REQ-035 SHALL ignore start outside IDLE, and ignore abort in IDLE and DONE.
REQ-036 SHALL keep words_done stable from DONE until the next accepted start.

Reset
REQ-037 SHALL, while rst_n = 0, immediately force state IDLE and busy, done, mem_read, mem_write, mem_address, mem_data_write and words_done to 0, clearing the holding register.
REQ-038 SHALL, on reset mid-transfer, drop the transfer with no further memory access, and accept a new start on the first edge after rst_n rises.

Verification
REQ-039 SHALL pass: copy with src = 0x0010, dst = 0x0100, length = 4, mem[0x10..0x13] = A1,A2,A3,A4 -> mem[0x100..0x103] = A1..A4, busy for 8 cycles, one done pulse, words_done = 4.
REQ-040 SHALL pass: fill with dst = 0x0020, length = 3, fill_value = 0xBEEF -> 3 consecutive write cycles to 0x20..0x22, done on the next cycle, mem_read never asserted.
REQ-041 SHALL pass: start with length = 0 -> done pulse 1 cycle after start, no mem_read or mem_write, words_done = 0.
REQ-042 SHALL pass: copy with src = 0xFFFE, dst = 0x7FFF, length = 3 -> reads 0xFFFE, 0xFFFF, 0x0000 and writes 0x7FFF, 0x8000, 0x8001.
REQ-043 SHALL pass: copy length = 10 with abort held high in the WRITE cycle of word 3 -> words 0..2 written, words_done = 3, done pulse next cycle, no further access.
REQ-044 SHALL pass: rst_n low in the READ of word 2, start pulsed during busy -> outputs 0 at once, no memory write after reset, and the pulsed start is ignored.
